// File: rtl/enemy_scheduler_pkg.sv
// Shared definitions for the enemy scheduler: FSM states, sprite geometry, pixel widths
// and the movement direction codes used by the enemy engines.
package enemy_scheduler_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StGen,
        StApply,
        StDraw,
        StNext,
        StDone
    } sched_state_e;

    typedef enum logic [1:0] {
        DirUp,
        DirDown,
        DirLeft,
        DirRight
    } dir_e;

    localparam int unsigned SpriteW      = 16;
    localparam int unsigned SpriteH      = 16;
    localparam int unsigned SpritePixels = SpriteW * SpriteH;
    localparam int unsigned ColourW      = 6;
    localparam int unsigned XW           = 9;
    localparam int unsigned YW           = 8;

endpackage

// File: rtl/enemy_vga_mux.sv
// N-to-1 selector for a bank of sprite pixel streams onto one frame-buffer write port.
module enemy_vga_mux
    import enemy_scheduler_pkg::*;
#(
    parameter int unsigned NSrc = 4
) (
    input  logic [2:0]              sel_i,
    input  logic                    en_i,
    input  logic [XW*NSrc-1:0]      x_i,
    input  logic [YW*NSrc-1:0]      y_i,
    input  logic [ColourW*NSrc-1:0] colour_i,
    input  logic [NSrc-1:0]         write_i,
    output logic [XW-1:0]           x_o,
    output logic [YW-1:0]           y_o,
    output logic [ColourW-1:0]      colour_o,
    output logic                    write_o
);

    always_comb begin
        x_o      = '0;
        y_o      = '0;
        colour_o = '0;
        write_o  = 1'b0;
        for (int unsigned i = 0; i < NSrc; i++) begin
            if (sel_i == 3'(i)) begin
                x_o      = x_i[i*XW +: XW];
                y_o      = y_i[i*YW +: YW];
                colour_o = colour_i[i*ColourW +: ColourW];
                write_o  = write_i[i] & en_i;
            end
        end
    end

endmodule

// File: rtl/enemy_scheduler.sv
// Per-frame sequencer for the enemy engines: move generation, move application and sprite
// draw, one enemy at a time, with dead-slot skipping, move throttling and a draw watchdog.
module enemy_scheduler
    import enemy_scheduler_pkg::*;
#(
    parameter int unsigned N_ENEMY      = 4,
    parameter int unsigned MOVE_DIV     = 2,
    parameter int unsigned DRAW_TIMEOUT = 2 * SpritePixels
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       init_req_i,
    input  logic [N_ENEMY-1:0]         alive_i,
    input  logic [N_ENEMY-1:0]         draw_done_i,
    input  logic [XW*N_ENEMY-1:0]      en_x_i,
    input  logic [YW*N_ENEMY-1:0]      en_y_i,
    input  logic [ColourW*N_ENEMY-1:0] en_colour_i,
    input  logic [N_ENEMY-1:0]         en_write_i,
    output logic                       init_o,
    output logic                       idle_o,
    output logic [N_ENEMY-1:0]         gen_move_o,
    output logic [N_ENEMY-1:0]         apply_move_o,
    output logic [N_ENEMY-1:0]         draw_o,
    output logic [XW-1:0]              vga_x_o,
    output logic [YW-1:0]              vga_y_o,
    output logic [ColourW-1:0]         vga_colour_o,
    output logic                       vga_write_o,
    output logic [2:0]                 cur_enemy_o,
    output logic                       done_o,
    output logic                       timeout_err_o
);

    localparam int unsigned WdW = $clog2(DRAW_TIMEOUT) + 1;

    sched_state_e       state_q;
    logic [2:0]         cur_q;
    logic [3:0]         frame_q;
    logic               move_q;
    logic [WdW-1:0]     wdog_q;
    logic               timeout_q, init_q, idle_q, done_q;
    logic [N_ENEMY-1:0] gen_q, apply_q, draw_q;

    logic [7:0]   alive_pad, done_pad, cand_oh, cur_oh;
    logic [2:0]   cand;
    logic         cand_move;
    sched_state_e entry_st;

    // Slot about to be entered: enemy 0 from IDLE, otherwise the one after cur_q.
    always_comb begin
        alive_pad = 8'(alive_i);
        done_pad  = 8'(draw_done_i);
        cand      = (state_q == StIdle) ? 3'd0 : cur_q + 3'd1;
        cand_move = (state_q == StIdle) ? (frame_q == 4'd0) : move_q;
        cand_oh   = 8'd1 << cand;
        cur_oh    = 8'd1 << cur_q;
        if (!alive_pad[cand]) begin
            entry_st = StNext;
        end else if (cand_move) begin
            entry_st = StGen;
        end else begin
            entry_st = StDraw;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StInit;
            cur_q     <= '0;
            frame_q   <= '0;
            move_q    <= 1'b0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            init_q    <= 1'b1;
            idle_q    <= 1'b0;
            done_q    <= 1'b0;
            gen_q     <= '0;
            apply_q   <= '0;
            draw_q    <= '0;
        end else if (init_req_i) begin
            state_q   <= StInit;
            cur_q     <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            init_q    <= 1'b1;
            idle_q    <= 1'b0;
            done_q    <= 1'b0;
            gen_q     <= '0;
            apply_q   <= '0;
            draw_q    <= '0;
        end else begin
            init_q  <= 1'b0;
            done_q  <= 1'b0;
            gen_q   <= '0;
            apply_q <= '0;
            unique case (state_q)
                StInit: begin
                    state_q <= StIdle;
                    idle_q  <= 1'b1;
                    frame_q <= '0;
                    cur_q   <= '0;
                end
                StIdle: begin
                    if (start_i) begin
                        idle_q  <= 1'b0;
                        cur_q   <= '0;
                        move_q  <= cand_move;
                        frame_q <= (frame_q == 4'(MOVE_DIV - 1)) ? 4'd0 : frame_q + 4'd1;
                        wdog_q  <= '0;
                        state_q <= entry_st;
                        gen_q   <= (entry_st == StGen) ? cand_oh[N_ENEMY-1:0] : '0;
                        draw_q  <= (entry_st == StDraw) ? cand_oh[N_ENEMY-1:0] : '0;
                    end
                end
                StGen: begin
                    apply_q <= cur_oh[N_ENEMY-1:0];
                    state_q <= StApply;
                end
                StApply: begin
                    draw_q  <= cur_oh[N_ENEMY-1:0];
                    wdog_q  <= '0;
                    state_q <= StDraw;
                end
                StDraw: begin
                    if (done_pad[cur_q]) begin
                        draw_q  <= '0;
                        state_q <= StNext;
                    end else if (wdog_q == WdW'(DRAW_TIMEOUT - 1)) begin
                        draw_q    <= '0;
                        timeout_q <= 1'b1;
                        state_q   <= StNext;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                StNext: begin
                    wdog_q <= '0;
                    if (cur_q == 3'(N_ENEMY - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cur_q   <= cand;
                        state_q <= entry_st;
                        gen_q   <= (entry_st == StGen) ? cand_oh[N_ENEMY-1:0] : '0;
                        draw_q  <= (entry_st == StDraw) ? cand_oh[N_ENEMY-1:0] : '0;
                    end
                end
                StDone: begin
                    idle_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    init_q  <= 1'b1;
                    state_q <= StInit;
                end
            endcase
        end
    end

    enemy_vga_mux #(
        .NSrc(N_ENEMY)
    ) u_vga_mux (
        .sel_i   (cur_q),
        .en_i    (state_q == StDraw),
        .x_i     (en_x_i),
        .y_i     (en_y_i),
        .colour_i(en_colour_i),
        .write_i (en_write_i),
        .x_o     (vga_x_o),
        .y_o     (vga_y_o),
        .colour_o(vga_colour_o),
        .write_o (vga_write_o)
    );

    assign init_o        = init_q;
    assign idle_o        = idle_q;
    assign gen_move_o    = gen_q;
    assign apply_move_o  = apply_q;
    assign draw_o        = draw_q;
    assign cur_enemy_o   = cur_q;
    assign done_o        = done_q;
    assign timeout_err_o = timeout_q;

endmodule
